// File: rtl/uart_receiver.sv
// ============================================================================
// Module : uart_receiver
// Purpose: Serial-to-parallel UART receive stage. Works from a 16x
//          oversampling strobe (sample_ENABLE) supplied by the baud
//          controller. A frame is one start bit (0), DATA_BITS data bits sent
//          LSB first, an optional parity bit and one stop bit (1). Each
//          completed frame updates Rx_DATA and the error flags. A clean frame
//          also raises a one-clock Rx_VALID pulse.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..8)
//   OVERSAMPLE  sample_ENABLE ticks per bit period (16 with a 4-bit counter)
//   PARITY_EN   1 = parity bit follows the data, 0 = no parity bit
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   Rx_EN          in   receiver enable; low holds the receiver in IDLE
//   sample_ENABLE  in   one-clock strobe at OVERSAMPLE x baud ("tick")
//   RxD            in   asynchronous serial line, idle high
//   Rx_DATA        out  data of the last completed frame
//   Rx_VALID       out  one-clock pulse when the last frame was error free
//   Rx_FERROR      out  stop bit of the last frame was sampled low
//   Rx_PERROR      out  parity of the last frame did not match
// ============================================================================
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx_EN,
    input  logic                 sample_ENABLE,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_FERROR,
    output logic                 Rx_PERROR
);

    // The bit index only has to count to DATA_BITS-1.
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // The start bit is checked halfway through its period. Once that check
    // succeeds, the counter is cleared. Every later bit is then sampled a
    // full bit period after the previous sample, so each sample lands near
    // the middle of its bit.
    localparam logic [3:0]       CNT_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       CNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_out_q, ferr_out_d;
    logic                   perr_out_q, perr_out_d;
    logic                   rxd_meta_q, rxd_meta_d;
    logic                   rxd_s_q, rxd_s_d;
    logic                   parity_exp;

    // Register bank. All flops reset asynchronously. The two synchroniser
    // flops reset to 1, so the receiver never sees a false start bit while
    // it leaves reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_out_q <= 1'b0;
            perr_out_q <= 1'b0;
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_out_q <= ferr_out_d;
            perr_out_q <= perr_out_d;
            rxd_meta_q <= rxd_meta_d;
            rxd_s_q    <= rxd_s_d;
        end
    end

    // Next-state and datapath logic. Every register holds its value unless a
    // tick moves the frame forward. Rx_VALID is the one exception: it
    // defaults to 0, so it can only ever be high for a single clock.
    //
    // Dropping Rx_EN forces a return to IDLE on the next clock, whether or
    // not a tick is present. The frame in progress is dropped. The previously
    // reported data and error flags stay as they were.
    //
    // The error flags are cleared only when a start bit is confirmed. This
    // means a rejected glitch leaves the previous frame's status untouched.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_out_d = ferr_out_q;
        perr_out_d = perr_out_q;
        rxd_meta_d = RxD;
        rxd_s_d    = rxd_meta_q;
        parity_exp = (^shift_q) ^ (PARITY_ODD != 0);

        if (!Rx_EN) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (sample_ENABLE) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rxd_s_q) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end

                ST_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        if (!rxd_s_q) begin
                            state_d    = ST_DATA;
                            idx_d      = '0;
                            perr_d     = 1'b0;
                            ferr_out_d = 1'b0;
                            perr_out_d = 1'b0;
                        end else begin
                            // The line went high again before mid-bit, so
                            // this was a glitch and not a start bit.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end

                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        // Bits arrive LSB first and shift in from the top,
                        // so the first bit ends up in bit 0.
                        shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end

                ST_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_STOP;
                        if (rxd_s_q != parity_exp) begin
                            perr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end

                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        // Rx_DATA is updated on every frame, even a bad one.
                        // Only a clean frame raises Rx_VALID. After a low stop
                        // bit, the receiver goes back to IDLE. If the line is
                        // still low there (a break), IDLE detects a new start
                        // bit straight away.
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                        data_d     = shift_q;
                        ferr_out_d = ~rxd_s_q;
                        perr_out_d = perr_q;
                        valid_d    = rxd_s_q & ~perr_q;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // The outputs come directly from flops, so downstream logic sees no
    // glitches.
    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_FERROR = ferr_out_q;
    assign Rx_PERROR = perr_out_q;

endmodule
